// File: rtl/param_cache.sv
// Direct-mapped, write-through, write-no-allocate cache with valid/ready CPU and memory ports
// and a coherence invalidate port. Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module param_cache #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int WORDS_PER_LINE = 2,
  parameter int LINES          = 128
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cpu_req_valid,
  output logic                             cpu_req_ready,
  input  logic                             cpu_req_write,
  input  logic [ADDR_W-1:0]                cpu_req_addr,
  input  logic [DATA_W-1:0]                cpu_req_wdata,
  output logic                             cpu_resp_valid,
  output logic [DATA_W-1:0]                cpu_resp_data,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_write,
  output logic [ADDR_W-1:0]                mem_req_addr,
  output logic [DATA_W-1:0]                mem_req_wdata,
  input  logic                             mem_resp_valid,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_resp_data,
  input  logic                             inval_valid,
  input  logic [ADDR_W-1:0]                inval_addr
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
`endif
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MEM_REQ  = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
  localparam logic [2:0] S_RESPOND  = 3'd4;

  // Word 0 sits in the most significant slot of a line.
  function automatic logic [DATA_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off);
    logic [DATA_W-1:0] w;
    w = {DATA_W{1'b0}};
    for (int k = 0; k < WORDS_PER_LINE; k++)
      if (OFF_W'(k) == off) w = line[LINE_W-1-k*DATA_W -: DATA_W];
    return w;
  endfunction

  function automatic logic [LINE_W-1:0] set_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [DATA_W-1:0] w);
    logic [LINE_W-1:0] l;
    l = line;
    for (int k = 0; k < WORDS_PER_LINE; k++)
      if (OFF_W'(k) == off) l[LINE_W-1-k*DATA_W -: DATA_W] = w;
    return l;
  endfunction

  logic [2:0]        state_r, next_state_s;
  logic              req_write_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [DATA_W-1:0] req_wdata_r;
  logic              stale_r;
  logic [LINE_W-1:0] data_mem_r [LINES];
  logic [TAG_W-1:0]  tag_mem_r  [LINES];
  logic [LINES-1:0]  valid_r;

  logic [TAG_W-1:0]  req_tag_s, inval_tag_s;
  logic [IDX_W-1:0]  req_idx_s, inval_idx_s;
  logic [OFF_W-1:0]  req_off_s;
  logic              hit_s, inval_hit_s, inval_pend_s, fill_s, wr_upd_s;
  logic              unused_inval_off_s;

  assign req_tag_s          = req_addr_r[ADDR_W-1 -: TAG_W];
  assign req_idx_s          = req_addr_r[OFF_W +: IDX_W];
  assign req_off_s          = req_addr_r[OFF_W-1:0];
  assign inval_tag_s        = inval_addr[ADDR_W-1 -: TAG_W];
  assign inval_idx_s        = inval_addr[OFF_W +: IDX_W];
  assign unused_inval_off_s = ^inval_addr[OFF_W-1:0];

  assign hit_s        = valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s);
  assign inval_hit_s  = inval_valid && valid_r[inval_idx_s] && (tag_mem_r[inval_idx_s] == inval_tag_s);
  // Matches the in-flight request address, independent of what the array currently holds.
  assign inval_pend_s = inval_valid && (inval_tag_s == req_tag_s) && (inval_idx_s == req_idx_s);
  assign fill_s       = (state_r == S_MEM_WAIT) && mem_resp_valid && !req_write_r;
  assign wr_upd_s     = (state_r == S_LOOKUP) && req_write_r && hit_s;

  // Next-state selection for the request sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:     if (cpu_req_valid && cpu_req_ready) next_state_s = S_LOOKUP;
                  else next_state_s = S_IDLE;
      S_LOOKUP:   if (!req_write_r && hit_s) next_state_s = S_RESPOND;
                  else next_state_s = S_MEM_REQ;
      S_MEM_REQ:  if (mem_req_ready) next_state_s = S_MEM_WAIT;
                  else next_state_s = S_MEM_REQ;
      S_MEM_WAIT: if (mem_resp_valid) next_state_s = S_RESPOND;
                  else next_state_s = S_MEM_WAIT;
      S_RESPOND:  next_state_s = S_IDLE;
      default:    next_state_s = S_IDLE;
    endcase
  end

  // Sequencer state, request latch and all registered port outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= S_IDLE;
      req_write_r    <= 1'b0;
      req_addr_r     <= {ADDR_W{1'b0}};
      req_wdata_r    <= {DATA_W{1'b0}};
      cpu_req_ready  <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_data  <= {DATA_W{1'b0}};
      mem_req_valid  <= 1'b0;
      mem_req_write  <= 1'b0;
      mem_req_addr   <= {ADDR_W{1'b0}};
      mem_req_wdata  <= {DATA_W{1'b0}};
    end else begin
      state_r        <= next_state_s;
      cpu_req_ready  <= (next_state_s == S_IDLE);
      cpu_resp_valid <= (next_state_s == S_RESPOND);
      mem_req_valid  <= (next_state_s == S_MEM_REQ);
      case (state_r)
        S_IDLE: begin
          if (cpu_req_valid && cpu_req_ready) begin
            req_write_r <= cpu_req_write;
            req_addr_r  <= cpu_req_addr;
            req_wdata_r <= cpu_req_wdata;
          end
        end
        S_LOOKUP: begin
          if (!req_write_r && hit_s) begin
            cpu_resp_data <= get_word(data_mem_r[req_idx_s], req_off_s);
          end else begin
            mem_req_write <= req_write_r;
            mem_req_addr  <= req_write_r ? req_addr_r
                                         : {req_addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_req_wdata <= req_write_r ? req_wdata_r : {DATA_W{1'b0}};
          end
        end
        S_MEM_WAIT: begin
          if (mem_resp_valid)
            cpu_resp_data <= req_write_r ? req_wdata_r : get_word(mem_resp_data, req_off_s);
        end
        default: ;
      endcase
    end
  end

  // Stale-fill guard: the pending read line was invalidated before its fill landed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stale_r <= 1'b0;
    else if (state_r == S_IDLE) stale_r <= 1'b0;
    else if (((state_r == S_MEM_REQ) || (state_r == S_MEM_WAIT)) && !req_write_r && inval_pend_s)
      stale_r <= 1'b1;
    else stale_r <= stale_r;
  end

  // Line valid flags; an invalidate in the same cycle always wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= {LINES{1'b0}};
    end else begin
      if (fill_s) valid_r[req_idx_s] <= !(stale_r || inval_pend_s);
      if (inval_hit_s) valid_r[inval_idx_s] <= 1'b0;
    end
  end

  // Line data and tag storage: refill on read miss, word merge on write hit.
  always_ff @(posedge clock) begin
    if (fill_s) begin
      data_mem_r[req_idx_s] <= mem_resp_data;
      tag_mem_r[req_idx_s]  <= req_tag_s;
    end else if (wr_upd_s) begin
      data_mem_r[req_idx_s] <= set_word(data_mem_r[req_idx_s], req_off_s, req_wdata_r);
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating read hit/miss counters, sampled in LOOKUP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else if ((state_r == S_LOOKUP) && !req_write_r) begin
      if (hit_s) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
